// File: rtl/aes_pkg.sv
// Shared AES datapath types and GF(2^8) helpers.
// Used by the column-serial MixColumns sequencer and its column mixer.
package aes_pkg;

    typedef logic [127:0] state_t;
    typedef logic [31:0]  column_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mcs_state_e;

    // Low byte of the AES field polynomial x^8 + x^4 + x^3 + x + 1
    localparam logic [7:0] AES_POLY_LOW = 8'h1B;

    // Multiply by x in GF(2^8), reducing modulo the AES polynomial
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY_LOW : 8'h00);
    endfunction

endpackage

// File: rtl/mixcol_column_unit.sv
// Combinational MixColumns for one 32-bit column (row 0 in [31:24]).
module mixcol_column_unit
    import aes_pkg::*;
(
    input  column_t col_in,
    output column_t col_out
);

    logic [7:0] a0, a1, a2, a3;
    logic [7:0] d0, d1, d2, d3;   // 2*a
    logic [7:0] t0, t1, t2, t3;   // 3*a

    assign a0 = col_in[31:24];
    assign a1 = col_in[23:16];
    assign a2 = col_in[15:8];
    assign a3 = col_in[7:0];

    assign d0 = xtime(a0);
    assign d1 = xtime(a1);
    assign d2 = xtime(a2);
    assign d3 = xtime(a3);

    assign t0 = d0 ^ a0;
    assign t1 = d1 ^ a1;
    assign t2 = d2 ^ a2;
    assign t3 = d3 ^ a3;

    assign col_out[31:24] = d0 ^ t1 ^ a2 ^ a3;
    assign col_out[23:16] = a0 ^ d1 ^ t2 ^ a3;
    assign col_out[15:8]  = a0 ^ a1 ^ d2 ^ t3;
    assign col_out[7:0]   = t0 ^ a1 ^ a2 ^ d3;

endmodule

// File: rtl/mix_columns_seq.sv
// Column-serial MixColumns sequencer: one shared column mixer, four
// cycles per state, valid/ready on both sides.
// Optional feature macro: MIX_COLUMNS_SEQ_LAST_BYPASS_EN -- when defined,
// a state captured with in_last=1 passes through unmixed (final round).
module mix_columns_seq
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    mcs_state_e state, next_state;
    logic [1:0] col;
    state_t     cap;      // captured state; mixed columns overwrite it in place
    state_t     res;      // published result, only updated on the final column
    column_t    col_in;
    column_t    col_mix;
    column_t    col_res;
    logic [6:0] col_lo;   // bit offset of column `col` (column 0 is the MSBs)
    logic       accept;

    assign col_lo = {~col, 5'b0_0000};
    assign col_in = cap[col_lo +: 32];
    assign accept = in_valid & in_ready;

    mixcol_column_unit u_mix (
        .col_in  (col_in),
        .col_out (col_mix)
    );

`ifdef MIX_COLUMNS_SEQ_LAST_BYPASS_EN
    logic last_q;

    assign col_res = last_q ? col_in : col_mix;

    // Final-round flag travels with the captured state
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_q <= 1'b0;
        else if (accept)
            last_q <= in_last;
    end
`else
    logic unused_last;

    assign unused_last = in_last;
    assign col_res     = col_mix;
`endif

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state and handshake outputs
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    next_state = BUSY;
            end
            BUSY: begin
                busy = 1'b1;
                if (col == 2'd3)
                    next_state = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready)
                    next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Capture, per-column write-back and result publish on the last column
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= 2'd0;
            cap <= '0;
            res <= '0;
        end else if (accept) begin
            col <= 2'd0;
            cap <= in_data;
        end else if (state == BUSY) begin
            cap[col_lo +: 32] <= col_res;
            col               <= col + 2'd1;
            if (col == 2'd3)
                res <= {cap[127:32], col_res};
        end
    end

    assign out_data = res;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Self-checking bench for mix_columns_seq: random and directed states
// compared against a matrix-multiply GF(2^8) reference model.
module tb_mix_columns_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    int errors = 0;
    int checks = 0;

`ifdef MIX_COLUMNS_SEQ_LAST_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;

    mix_columns_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] model_mix(input logic [127:0] s);
        logic [7:0]   coef [4];
        logic [7:0]   a [4];
        logic [7:0]   b;
        logic [127:0] r = '0;
        coef[0] = 8'd2; coef[1] = 8'd3; coef[2] = 8'd1; coef[3] = 8'd1;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++)
                a[j] = s[127 - 32*c - 8*j -: 8];
            for (int rw = 0; rw < 4; rw++) begin
                b = 8'h00;
                for (int j = 0; j < 4; j++)
                    b = b ^ gmul(coef[(j - rw + 4) % 4], a[j]);
                r[127 - 32*c - 8*rw -: 8] = b;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] expect_state(input logic [127:0] d, input bit last);
        return (last && BYPASS) ? d : model_mix(d);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a state until accepted; returns at the sample point after the accept edge
    task automatic send(input logic [127:0] d, input bit last, output bit ok);
        int n = 0;
        ok       = 1'b0;
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        while (!ok && n < 20) begin
            if (in_ready) ok = 1'b1;
            step();
            n++;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        step(); step();
        @(negedge clk) rst = 1'b0;
        step();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++;
        if (out_data !== 128'h0) begin errors++; $display("FAIL reset_out_data got=%h want=0", out_data); end
    endtask

    task automatic test_fips(input bit last, input logic [127:0] want, input string tag);
        bit ok, seen_ready;
        int first, lowcnt;
        logic [127:0] got;
        out_ready = 1'b1;
        send(FIPS_IN, last, ok);
        first = -1; lowcnt = 0; seen_ready = 1'b0; got = '0;
        for (int k = 0; k < 12; k++) begin
            if (out_valid && first < 0) begin first = k; got = out_data; end
            if (!seen_ready) begin
                if (in_ready) seen_ready = 1'b1;
                else          lowcnt++;
            end
            step();
        end
        checks++;
        if (!ok || first != 4) begin errors++; $display("FAIL %s_latency got=%0d want=4 (accepted=%b)", tag, first, ok); end
        checks++;
        if (lowcnt != 5) begin errors++; $display("FAIL %s_in_ready_low got=%0d want=5", tag, lowcnt); end
        checks++;
        if (got !== want) begin errors++; $display("FAIL %s_data got=%h want=%h", tag, got, want); end
    endtask

    task automatic test_columns();
        bit ok;
        int n;
        out_ready = 1'b1;
        send(128'hdb135345_f20a225c_01010101_d4d4d4d5, 1'b0, ok);
        wait_out(n);
        checks++;
        if (!ok || n != 4 || out_data !== 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6) begin
            errors++;
            $display("FAIL column_vectors got=%h lat=%0d want=8e4da1bc9fdc589d01010101d5d5d7d6 lat=4", out_data, n);
        end
        step();
    endtask

    task automatic test_random();
        bit ok, last;
        int n, stall;
        logic [127:0] d, want;
        for (int t = 0; t < 12; t++) begin
            d     = {$urandom, $urandom, $urandom, $urandom};
            last  = 1'($urandom_range(0, 1));
            want  = expect_state(d, last);
            out_ready = 1'b0;
            send(d, last, ok);
            wait_out(n);
            stall = $urandom_range(0, 3);
            for (int s = 0; s < stall; s++) step();
            checks++;
            if (!ok || !out_valid || out_data !== want) begin
                errors++;
                $display("FAIL random_%0d got=%h valid=%b want=%h last=%b", t, out_data, out_valid, want, last);
            end
            out_ready = 1'b1;
            step();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL random_%0d_release got valid=%b ready=%b want valid=0 ready=1", t, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int n, bad;
        logic [127:0] d, hold;
        d = {$urandom, $urandom, $urandom, $urandom};
        out_ready = 1'b0;
        send(d, 1'b0, ok);
        wait_out(n);
        hold = out_data;
        checks++;
        if (!ok || hold !== model_mix(d)) begin errors++; $display("FAIL bp_data got=%h want=%h", hold, model_mix(d)); end
        in_data  = ~d;
        in_valid = 1'b1;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (out_data !== hold || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL bp_hold got=%0d unstable cycles want=0", bad); end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== hold) begin
            errors++;
            $display("FAIL bp_release got valid=%b ready=%b data=%h want 0/1/%h", out_valid, in_ready, out_data, hold);
        end
        step();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL bp_no_accept got busy=%b want=0", busy); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n, seen;
        out_ready = 1'b1;
        send({$urandom, $urandom, $urandom, $urandom}, 1'b0, ok);
        step(); step();                 // col = 2
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 128'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset got valid=%b ready=%b busy=%b data=%h want 0/1/0/0", out_valid, in_ready, busy, out_data);
        end
        @(negedge clk) rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL midreset_no_output got=%0d want=0", seen); end
        send({4{32'hdb135345}}, 1'b0, ok);
        wait_out(n);
        checks++;
        if (!ok || n != 4 || out_data !== {4{32'h8e4da1bc}}) begin
            errors++;
            $display("FAIL midreset_next got=%h lat=%0d want=%h lat=4", out_data, n, {4{32'h8e4da1bc}});
        end
        step();
    endtask

    task automatic test_back_to_back();
        int acc[$];
        logic [127:0] outs[$];
        logic [127:0] a, b;
        bit took;
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
        out_ready = 1'b1;
        in_last   = 1'b0;
        in_data   = a;
        in_valid  = 1'b1;
        for (int s = 0; s < 30; s++) begin
            took = in_valid && in_ready;
            if (took) acc.push_back(s);
            if (out_valid && out_ready) outs.push_back(out_data);
            step();
            if (took) begin
                if (acc.size() == 1) in_data  = b;
                else                 in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (acc.size() != 2 || acc[1] - acc[0] != 6) begin
            errors++;
            $display("FAIL b2b_interval got accepts=%0d gap=%0d want 2/6", acc.size(),
                     (acc.size() >= 2) ? acc[1] - acc[0] : -1);
        end
        checks++;
        if (outs.size() != 2) begin
            errors++;
            $display("FAIL b2b_outputs got=%0d want=2", outs.size());
        end else begin
            checks++;
            if (outs[0] !== model_mix(a)) begin errors++; $display("FAIL b2b_first got=%h want=%h", outs[0], model_mix(a)); end
            checks++;
            if (outs[1] !== model_mix(b)) begin errors++; $display("FAIL b2b_second got=%h want=%h", outs[1], model_mix(b)); end
        end
    endtask

    initial begin
        test_reset();
        test_fips(1'b0, FIPS_OUT, "fips");
        test_columns();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_fips(1'b1, BYPASS ? FIPS_IN : FIPS_OUT, "last");
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
